// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encodings, port IDs
// and bus widths.
package ram_arb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   localparam logic PORT_IF   = 1'b0;
   localparam logic PORT_DATA = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin picker: on a tie, the port that did not
// win last time is chosen.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   assign grant_valid = |req;

   always_comb begin
      grant_id = 1'b0;
      if (req == 2'b11)
         grant_id = ~last_grant;
      else if (req[1])
         grant_id = 1'b1;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin controller sharing one 32-bit byte-addressed RAM between the
// fetch port (0, read-only) and the data port (1). Optional misaligned-access
// trapping is enabled by defining RAM_ARB_ALIGN_CHECK_EN.
module ram_arbiter #(
   parameter int DATA_W     = ram_arb_pkg::DATA_W,
   parameter int ADDR_W     = ram_arb_pkg::ADDR_W,
   parameter int RESET_PRIO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic [ADDR_W-1:0] p0_addr,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_readEnable,
   output logic              ram_writeEnable,
   output logic [DATA_W-1:0] ram_writeData,
   input  logic [DATA_W-1:0] ram_readData
);

   import ram_arb_pkg::*;

   // Pointer holds the last winner; reset value makes RESET_PRIO win first.
   localparam logic PTR_RST = (RESET_PRIO == 1) ? PORT_IF : PORT_DATA;

   state_t            state;
   logic              ptr;
   logic              owner;
   logic              we_q;
   logic              gvalid;
   logic              gid;
   logic [ADDR_W-1:0] gaddr;
   logic              gwe;
   logic              bad;

   rr_arbiter2 u_rr (
      .req         ({p1_req, p0_req}),
      .last_grant  (ptr),
      .grant_valid (gvalid),
      .grant_id    (gid)
   );

   assign gaddr = gid ? p1_addr : p0_addr;
   assign gwe   = gid & p1_we;

`ifdef RAM_ARB_ALIGN_CHECK_EN
   assign bad = misaligned(gaddr[1:0]);
`else
   assign bad = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         ptr             <= PTR_RST;
         owner           <= PORT_IF;
         we_q            <= 1'b0;
         p0_ack          <= 1'b0;
         p1_ack          <= 1'b0;
         p0_err          <= 1'b0;
         p1_err          <= 1'b0;
         p0_rdata        <= '0;
         p1_rdata        <= '0;
         ram_address     <= '0;
         ram_writeData   <= '0;
         ram_readEnable  <= 1'b0;
         ram_writeEnable <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gvalid) begin
                  owner         <= gid;
                  we_q          <= gwe;
                  ram_address   <= gaddr;
                  ram_writeData <= gid ? p1_wdata : '0;
                  if (bad) begin
                     // Trapped access: answer at once, never touch the RAM.
                     state  <= RESP;
                     ptr    <= gid;
                     p0_ack <= (gid == PORT_IF);
                     p1_ack <= (gid == PORT_DATA);
                     p0_err <= (gid == PORT_IF);
                     p1_err <= (gid == PORT_DATA);
                  end else begin
                     state           <= ACCESS;
                     ram_readEnable  <= ~gwe;
                     ram_writeEnable <= gwe;
                  end
               end
            end
            ACCESS: begin
               ram_readEnable  <= 1'b0;
               ram_writeEnable <= 1'b0;
               if (!we_q) begin
                  if (owner == PORT_DATA) p1_rdata <= ram_readData;
                  else                    p0_rdata <= ram_readData;
               end
               ptr    <= owner;
               p0_ack <= (owner == PORT_IF);
               p1_ack <= (owner == PORT_DATA);
               state  <= RESP;
            end
            RESP: begin
               p0_ack <= 1'b0;
               p1_ack <= 1'b0;
               p0_err <= 1'b0;
               p1_err <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter with a byte-addressed big-endian
// RAM model that updates on negedge clk.
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 1'b0;
   logic [31:0] p0_addr = '0;
   logic        p0_ack;
   logic [31:0] p0_rdata;
   logic        p0_err;
   logic        p1_req = 1'b0;
   logic        p1_we = 1'b0;
   logic [31:0] p1_addr = '0;
   logic [31:0] p1_wdata = '0;
   logic        p1_ack;
   logic [31:0] p1_rdata;
   logic        p1_err;
   logic [31:0] ram_address;
   logic        ram_readEnable;
   logic        ram_writeEnable;
   logic [31:0] ram_writeData;
   logic [31:0] ram_readData = '0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
      .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .ram_address(ram_address), .ram_readEnable(ram_readEnable),
      .ram_writeEnable(ram_writeEnable), .ram_writeData(ram_writeData),
      .ram_readData(ram_readData)
   );

   logic [7:0] mem [256];
   int we_cnt = 0;
   int re_cnt = 0;

   function automatic logic [7:0] img(input int a);
      return 8'((a * 37 + 11) & 255);
   endfunction

   function automatic logic [31:0] word(input int a);
      return {mem[8'(a)], mem[8'(a + 1)], mem[8'(a + 2)], mem[8'(a + 3)]};
   endfunction

   always @(negedge clk) begin
      if (ram_writeEnable) begin
         for (int i = 0; i < 4; i++)
            mem[8'(int'(ram_address[7:0]) + i)] = ram_writeData[31 - 8 * i -: 8];
         we_cnt++;
      end
      if (ram_readEnable) begin
         ram_readData = word(int'(ram_address[7:0]));
         re_cnt++;
      end
   end

   typedef struct {
      logic        port;
      logic        rd;
      logic [31:0] data;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] shadow [2];
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      p0_req = 1'b0;
      p1_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      shadow[0] = '0;
      shadow[1] = '0;
   endtask

   // Pop the oldest expectation and compare it against the acking port.
   task automatic check_ack(input int n);
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      chk("ack_owner", {31'b0, p1_ack}, {31'b0, e.port});
      chk("ack_onehot", {31'b0, p0_ack ^ p1_ack}, 32'd1);
      chk("latency", 32'(n), 32'(e.lat));
      chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
      chk("err", {31'b0, e.port ? p1_err : p0_err}, {31'b0, e.err});
      chk("other_rdata", e.port ? p0_rdata : p1_rdata, shadow[!e.port]);
      shadow[e.port] = e.data;
   endtask

   task automatic xact(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
      exp_t e;
      logic mis;
      int   n;
      logic got;
      @(posedge clk);
      #1;
      mis = 1'b0;
`ifdef RAM_ARB_ALIGN_CHECK_EN
      mis = (addr[1:0] != 2'b00);
`endif
      e.port = port;
      e.rd   = ~we & ~mis;
      e.err  = mis;
      e.lat  = mis ? 1 : 2;
      e.data = e.rd ? word(int'(addr[7:0])) : shadow[port];
      sb.push_back(e);
      if (port) begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = 1'b1; p0_addr = addr;
      end
      n = 0;
      got = 1'b0;
      while (n < 10 && !got) begin
         @(posedge clk);
         #1;
         n++;
         if (p0_ack | p1_ack) got = 1'b1;
      end
      chk("ack_seen", {31'b0, got}, 32'd1);
      if (got) check_ack(n);
      else sb.delete();
      p0_req = 1'b0;
      p1_req = 1'b0;
   endtask

   initial begin
      int we0, re0, n, acks, cyc;
      for (int i = 0; i < 256; i++) mem[i] = img(i);

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_p0_ack", {31'b0, p0_ack}, 32'd0);
      chk("rst_p1_ack", {31'b0, p1_ack}, 32'd0);
      chk("rst_errs", {30'b0, p0_err, p1_err}, 32'd0);
      chk("rst_p0_rdata", p0_rdata, 32'd0);
      chk("rst_p1_rdata", p1_rdata, 32'd0);
      chk("rst_enables", {30'b0, ram_readEnable, ram_writeEnable}, 32'd0);
      chk("rst_ram_addr", ram_address, 32'd0);
      chk("rst_ram_wdata", ram_writeData, 32'd0);
      rst = 1'b0;
      shadow[0] = '0;
      shadow[1] = '0;

      // Port 1 write then read back
      we0 = we_cnt;
      xact(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      chk("wr_pulses", 32'(we_cnt - we0), 32'd1);
      chk("wr_word", word(16), 32'hDEADBEEF);
      xact(1'b1, 1'b0, 32'h10, 32'h0);
      chk("rd_back", p1_rdata, 32'hDEADBEEF);

      // Port 0 reads preloaded word 0
      xact(1'b0, 1'b0, 32'h00, 32'h0);
      chk("rd_img0", p0_rdata, {img(0), img(1), img(2), img(3)});
      chk("p1_kept", p1_rdata, 32'hDEADBEEF);

      // Port 0 unaligned read
      re0 = re_cnt;
      xact(1'b0, 1'b0, 32'h12, 32'h0);
`ifdef RAM_ARB_ALIGN_CHECK_EN
      chk("mis_no_ram", 32'(re_cnt - re0), 32'd0);
      chk("mis_rdata_kept", p0_rdata, {img(0), img(1), img(2), img(3)});
`else
      chk("unal_one_read", 32'(re_cnt - re0), 32'd1);
      chk("unal_bytes", p0_rdata, {8'hBE, 8'hEF, img(20), img(21)});
`endif

      // Both ports request continuously after reset: 1,0,1,0
      do_reset();
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.port = (k % 2 == 0);
         e.rd   = 1'b1;
         e.err  = 1'b0;
         e.lat  = (k == 0) ? 2 : 3;
         e.data = e.port ? word(8) : word(4);
         sb.push_back(e);
      end
      p0_req = 1'b1; p0_addr = 32'h04;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h08;
      n = 0; acks = 0; cyc = 0;
      while (acks < 4 && cyc < 30) begin
         @(posedge clk);
         #1;
         cyc++;
         n++;
         if (p0_ack | p1_ack) begin
            check_ack(n);
            n = 0;
            acks++;
         end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      chk("rr_acks", 32'(acks), 32'd4);
      sb.delete();

      // Reset during the ACCESS cycle of a write
      @(posedge clk);
      #1;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      chk("acc_we", {31'b0, ram_writeEnable}, 32'd1);
      rst = 1'b1;
      #1;
      p1_req = 1'b0;
      chk("arst_enables", {30'b0, ram_readEnable, ram_writeEnable}, 32'd0);
      chk("arst_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
      chk("arst_rdata", p0_rdata | p1_rdata, 32'd0);
      chk("arst_state", 32'(dut.state), 32'(IDLE));
      @(posedge clk);
      #1;
      rst = 1'b0;
      shadow[0] = '0;
      shadow[1] = '0;
      chk("arst_no_write", word(32), {img(32), img(33), img(34), img(35)});
      xact(1'b1, 1'b0, 32'h20, 32'h0);
      chk("arst_readback", p1_rdata, {img(32), img(33), img(34), img(35)});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin controller that shares the single byte-addressed 32-bit RAM between an instruction-fetch port (port 0, read-only) and a data port (port 1, read/write). It serialises requests, issues exactly one single-cycle RAM access per grant, and returns the read data or write completion to the owning requester through a req/ack handshake. It sits between the CPU front end and the RAM, and it drives every RAM control input.

## Interface
- DATA_W, 32, word width; fixed to the RAM word size.
- ADDR_W, 32, byte-address width.
- RESET_PRIO, 1, port that wins the first simultaneous request after reset.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  fetch request; held stable until p0_ack.
- p0_addr  in  ADDR_W  fetch byte address.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  fetched word; valid while p0_ack=1, held afterwards.
- p0_err  out  1  misaligned-access flag; qualified by p0_ack.
- p1_req  in  1  data request; p1_we, p1_addr and p1_wdata are held stable until p1_ack.
- p1_we  in  1  1=write, 0=read.
- p1_addr  in  ADDR_W  data byte address.
- p1_wdata  in  DATA_W  write word, big-endian order in RAM.
- p1_ack, p1_rdata, p1_err  out  1/DATA_W/1  same semantics as port 0.
- ram_address  out  ADDR_W  RAM address.
- ram_readEnable, ram_writeEnable  out  1  RAM enables.
- ram_writeData  out  DATA_W  RAM write word.
- ram_readData  in  DATA_W  RAM read word; updated by the RAM on negedge clk.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - With no request, stay in IDLE.
  - With a request, pick the winner and latch owner, address, we and wdata.
  - If both ports request, grant the port that does not hold the last-grant pointer.
  - After a grant, go to ACCESS, or to RESP with err when the access is misaligned (see Configuration).
- ACCESS:
  - Drive RAM enables from registered state only: ram_readEnable = ~we and ram_writeEnable = we, each high for exactly one cycle.
  - At the closing posedge, capture ram_readData into the owner's rdata register (reads only), update the pointer to the owner, and go to RESP.
- RESP:
  - Owner's ack is 1 for one cycle, then go to IDLE.
  - The non-owning port's ack and rdata do not change.
- Write accesses leave the owner's rdata unchanged.
- Requests that arrive while the FSM is busy are held by the requester and are arbitrated in the next IDLE cycle.
- A requester that drops req before its grant is not served; this is not an error.

## Timing
- Reset values: state=IDLE, pointer=port (1-RESET_PRIO), all ack/err=0, rdata=0, ram enables=0, ram_address/ram_writeData=0.
- Reset is asynchronous. If rst asserts mid-ACCESS, the enables drop immediately and a pending write is aborted (no RAM write).
- Latency, with req high before posedge k:
  - Grant at posedge k.
  - RAM access during cycle k→k+1.
  - ack high during cycle k+1→k+2, so the requester sees it at posedge k+2.
- Throughput: one access per 3 cycles.
- With both ports requesting continuously, grants alternate strictly.

## Configuration
- RAM_ARB_ALIGN_CHECK_EN defined:
  - In IDLE, a granted request with addr[1:0]≠0 goes directly to RESP with err=1.
  - No RAM enable is raised, rdata is unchanged, and the pointer still updates.
- RAM_ARB_ALIGN_CHECK_EN undefined:
  - err outputs are tied to 0 and the address is passed to the RAM unmodified.
  - Unaligned word accesses are byte-exact, as the RAM defines them.

## Structure
- Shared package/header ram_arb_pkg holds:
  - state encodings IDLE/ACCESS/RESP;
  - port IDs PORT_IF=0 and PORT_DATA=1;
  - DATA_W and ADDR_W constants.
- Sub-module rr_arbiter2 is a combinational 2-way round-robin picker. Inputs: req[1:0], last_grant. Outputs: grant_valid, grant_id.

## Test plan
- Port 1 writes 0xDEADBEEF to 0x10, then reads 0x10 → ram_writeEnable high exactly 1 cycle; read ack at posedge k+2 with p1_rdata=0xDEADBEEF; p1_err=0.
- Port 0 and port 1 raise req together after reset and hold it for 4 grants → grant order 1,0,1,0; acks 3 cycles apart; each rdata is delivered only to its owner.
- Port 0 reads 0x00 from the preloaded RAM image → p0_rdata equals the big-endian word formed from bytes 0..3; p1 outputs unchanged.
- Port 0 reads 0x12 → with the macro: p0_ack=1, p0_err=1, no RAM enable, p0_rdata unchanged; without the macro: a normal access returning bytes 0x12..0x15.
- rst pulsed during ACCESS of a port 1 write of 0x12345678 to 0x20 → enables drop asynchronously, word at 0x20 unchanged, all outputs at reset values, FSM in IDLE.
